// File: rtl/avalon_ram_agent_if.sv
// Avalon-MM bus bundle between a host (CPU port) and the RAM agent.
interface avalon_ram_agent_if;
    logic [31:0] address;
    logic [3:0]  byteenable;
    logic        read;
    logic        write;
    logic [31:0] host_to_agent;
    logic [31:0] agent_to_host;
    logic        waitrequest;
    logic        readdatavalid;
    logic        err;

    modport master (
        output address, byteenable, read, write, host_to_agent,
        input  agent_to_host, waitrequest, readdatavalid, err
    );

    modport slave (
        input  address, byteenable, read, write, host_to_agent,
        output agent_to_host, waitrequest, readdatavalid, err
    );
endinterface

// File: rtl/avalon_ram_agent.sv
// Avalon-MM RAM agent: wait-state insertion, byte-enabled writes, fixed-latency reads.
// Optional AVALON_RAM_RANGE_CHECK_EN: flag and suppress accesses at or above DEPTH*4.
module avalon_ram_agent #(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned WAIT_STATES  = 0
) (
    input logic               clk,
    input logic               rst,
    avalon_ram_agent_if.slave bus_io
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam int unsigned NB = DW / 8;
    localparam logic [CW-1:0] WS = CW'(WAIT_STATES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_c, accept_c, wr_acc_c, rd_acc_c, oor_c, err_q;
    logic [AW-1:0] idx_c;
    logic [DW-1:0] rdata_c;

    logic [DW-1:0]           mem_q  [DEPTH];
    logic [READ_LATENCY-1:0] vld_q;
    logic [DW-1:0]           data_q [READ_LATENCY];

    assign req_c    = bus_io.read | bus_io.write;
    assign accept_c = req_c && (cnt_q == WS);
    assign idx_c    = bus_io.address[2 +: AW];

`ifdef AVALON_RAM_RANGE_CHECK_EN
    localparam logic [33:0] LIMIT = 34'(DEPTH) << 2;
    assign oor_c   = {2'b00, bus_io.address} >= LIMIT;
    assign rdata_c = oor_c ? '0 : mem_q[idx_c];

    // Sticky until reset once any out-of-range transfer is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept_c && oor_c) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_addr_c;
    assign unused_addr_c = ^{bus_io.address[31:AW+2], bus_io.address[1:0]};
    assign oor_c   = 1'b0;
    assign rdata_c = mem_q[idx_c];
    assign err_q   = 1'b0;
`endif

    // Write wins over a simultaneous read; nothing is taken while reset is held
    assign wr_acc_c = accept_c && bus_io.write && !oor_c && !rst;
    assign rd_acc_c = accept_c && bus_io.read && !bus_io.write;

    always_comb begin
        cnt_d = cnt_q;
        if (!req_c || accept_c) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // RAM contents survive reset
    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (bus_io.byteenable[b]) begin
                    mem_q[idx_c][8*b +: 8] <= bus_io.host_to_agent[8*b +: 8];
                end
            end
        end
    end

    // Data stages only load with their valid, so the last stage holds between pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_acc_c;
            if (rd_acc_c) begin
                data_q[0] <= rdata_c;
            end
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign bus_io.waitrequest   = req_c && (cnt_q != WS);
    assign bus_io.readdatavalid = vld_q[READ_LATENCY-1];
    assign bus_io.agent_to_host = data_q[READ_LATENCY-1];
    assign bus_io.err           = err_q;
endmodule

// File: tb/tb_avalon_ram_agent.sv
// Directed bench for avalon_ram_agent: three instances cover the latency/wait-state corners.
module tb_avalon_ram_agent;
`ifdef AVALON_RAM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    avalon_ram_agent_if b0 ();
    avalon_ram_agent_if b1 ();
    avalon_ram_agent_if b2 ();

    avalon_ram_agent #(.DEPTH(1024), .READ_LATENCY(1), .WAIT_STATES(0)) u0 (.clk(clk), .rst(rst), .bus_io(b0.slave));
    avalon_ram_agent #(.DEPTH(1024), .READ_LATENCY(1), .WAIT_STATES(3)) u1 (.clk(clk), .rst(rst), .bus_io(b1.slave));
    avalon_ram_agent #(.DEPTH(1024), .READ_LATENCY(3), .WAIT_STATES(0)) u2 (.clk(clk), .rst(rst), .bus_io(b2.slave));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 16;
    vec_t vt [NV];
    logic [31:0] last_rd;
    logic [31:0] v2 [4];

    initial begin
        vt[0]  = '{1'b0, 1'b1, 32'h10,   4'hF, 32'h12345678, 32'h0};
        vt[1]  = '{1'b1, 1'b0, 32'h10,   4'hF, 32'h0,        32'h12345678};
        vt[2]  = '{1'b0, 1'b1, 32'h20,   4'hF, 32'hAABBCCDD, 32'h0};
        vt[3]  = '{1'b0, 1'b1, 32'h20,   4'h5, 32'h11223344, 32'h0};
        vt[4]  = '{1'b1, 1'b0, 32'h20,   4'hF, 32'h0,        32'hAA22CC44};
        vt[5]  = '{1'b0, 1'b1, 32'h24,   4'hF, 32'h01020304, 32'h0};
        vt[6]  = '{1'b0, 1'b1, 32'h24,   4'h0, 32'hFFFFFFFF, 32'h0};
        vt[7]  = '{1'b1, 1'b0, 32'h24,   4'hF, 32'h0,        32'h01020304};
        vt[8]  = '{1'b0, 1'b1, 32'h0,    4'hF, 32'h0BADF00D, 32'h0};
        vt[9]  = '{1'b0, 1'b1, 32'h1000, 4'hF, 32'hDEADBEEF, 32'h0};
        vt[10] = '{1'b1, 1'b0, 32'h0,    4'hF, 32'h0,        RC ? 32'h0BADF00D : 32'hDEADBEEF};
        vt[11] = '{1'b1, 1'b0, 32'h1000, 4'hF, 32'h0,        RC ? 32'h0 : 32'hDEADBEEF};
        vt[12] = '{1'b1, 1'b1, 32'h30,   4'hF, 32'h00000055, 32'h0};
        vt[13] = '{1'b1, 1'b0, 32'h30,   4'hF, 32'h0,        32'h00000055};
        vt[14] = '{1'b0, 1'b1, 32'h20,   4'hA, 32'h99887766, 32'h0};
        vt[15] = '{1'b1, 1'b0, 32'h20,   4'hF, 32'h0,        32'h99227744};
        v2[0] = 32'hA0A00000; v2[1] = 32'hB1B10001; v2[2] = 32'hC2C20002; v2[3] = 32'hD3D30003;

        b0.address = '0; b0.byteenable = '0; b0.read = 1'b0; b0.write = 1'b0; b0.host_to_agent = '0;
        b1.address = '0; b1.byteenable = '0; b1.read = 1'b0; b1.write = 1'b0; b1.host_to_agent = '0;
        b2.address = '0; b2.byteenable = '0; b2.read = 1'b0; b2.write = 1'b0; b2.host_to_agent = '0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst rdv0", 32'(b0.readdatavalid), 32'h0);
        chk("rst data0", b0.agent_to_host, 32'h0);
        chk("rst err0", 32'(b0.err), 32'h0);
        chk("rst wreq1", 32'(b1.waitrequest), 32'h0);
        chk("rst rdv2", 32'(b2.readdatavalid), 32'h0);
        chk("rst data2", b2.agent_to_host, 32'h0);

        // Instance 0: table of single transfers, each followed by an idle check cycle
        last_rd = 32'h0;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            b0.address = vt[i].addr; b0.byteenable = vt[i].be; b0.host_to_agent = vt[i].wdata;
            b0.read = vt[i].rd; b0.write = vt[i].wr;
            #1 chk($sformatf("v%0d wreq", i), 32'(b0.waitrequest), 32'h0);
            @(negedge clk);
            b0.read = 1'b0; b0.write = 1'b0;
            #1;
            chk($sformatf("v%0d rdv", i), 32'(b0.readdatavalid), 32'(vt[i].rd && !vt[i].wr));
            if (vt[i].rd && !vt[i].wr) last_rd = vt[i].exp;
            chk($sformatf("v%0d data", i), b0.agent_to_host, last_rd);
        end
        chk("err after wrap", 32'(b0.err), 32'(RC));

        // Write then read of the same word in the very next cycle
        @(negedge clk);
        b0.address = 32'h40; b0.byteenable = 4'hF; b0.host_to_agent = 32'h5A5AA5A5; b0.write = 1'b1;
        @(negedge clk);
        b0.write = 1'b0; b0.read = 1'b1;
        @(negedge clk);
        b0.read = 1'b0;
        #1;
        chk("b2b rdv", 32'(b0.readdatavalid), 32'h1);
        chk("b2b data", b0.agent_to_host, 32'h5A5AA5A5);
        @(negedge clk);
        #1 chk("b2b rdv pulse", 32'(b0.readdatavalid), 32'h0);

        // Instance 1: three wait states on write and read
        @(negedge clk);
        b1.address = 32'h8; b1.byteenable = 4'hF; b1.host_to_agent = 32'hCAFEF00D; b1.write = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("ws wr k%0d", k), 32'(b1.waitrequest), 32'(k < 3));
            @(negedge clk);
        end
        b1.write = 1'b0; b1.read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("ws rd k%0d", k), 32'(b1.waitrequest), 32'(k < 3));
            chk($sformatf("ws rdv k%0d", k), 32'(b1.readdatavalid), 32'h0);
            @(negedge clk);
        end
        b1.read = 1'b0;
        #1;
        chk("ws rdv", 32'(b1.readdatavalid), 32'h1);
        chk("ws data", b1.agent_to_host, 32'hCAFEF00D);

        // Abandon a read after two wait cycles
        @(negedge clk);
        b1.read = 1'b1;
        #1 chk("abort w0", 32'(b1.waitrequest), 32'h1);
        @(negedge clk);
        #1 chk("abort w1", 32'(b1.waitrequest), 32'h1);
        @(negedge clk);
        b1.read = 1'b0;
        #1 chk("abort idle wreq", 32'(b1.waitrequest), 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1 chk($sformatf("abort rdv k%0d", k), 32'(b1.readdatavalid), 32'h0);
        end
        // A fresh request must see the full wait count again
        b1.read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("retry k%0d", k), 32'(b1.waitrequest), 32'(k < 3));
            @(negedge clk);
        end
        b1.read = 1'b0;
        #1;
        chk("retry rdv", 32'(b1.readdatavalid), 32'h1);
        chk("retry data", b1.agent_to_host, 32'hCAFEF00D);

        // Instance 2: latency 3, load four words then read them back-to-back
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            b2.address = 32'(4 * k); b2.byteenable = 4'hF; b2.host_to_agent = v2[k]; b2.write = 1'b1;
        end
        @(negedge clk);
        b2.write = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            b2.read = (c < 4); b2.address = 32'(4 * c);
            #1;
            chk($sformatf("lat3 rdv c%0d", c), 32'(b2.readdatavalid), 32'(c >= 3 && c <= 6));
            if (c >= 3) chk($sformatf("lat3 data c%0d", c), b2.agent_to_host, v2[(c >= 6) ? 3 : c - 3]);
            chk($sformatf("lat3 wreq c%0d", c), 32'(b2.waitrequest), 32'h0);
        end

        // Reset with two reads in flight
        @(negedge clk);
        b2.read = 1'b1; b2.address = 32'h0;
        @(negedge clk);
        b2.address = 32'h4;
        @(negedge clk);
        b2.read = 1'b0;
        rst = 1'b1;
        #1;
        chk("inflight rst rdv", 32'(b2.readdatavalid), 32'h0);
        chk("inflight rst data", b2.agent_to_host, 32'h0);
        chk("inflight rst err0", 32'(b0.err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1 chk($sformatf("post rst rdv k%0d", k), 32'(b2.readdatavalid), 32'h0);
        end
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            b2.read = (c == 0); b2.address = 32'h4;
            #1;
            chk($sformatf("retain rdv c%0d", c), 32'(b2.readdatavalid), 32'(c == 3));
            if (c == 3) chk("retain data", b2.agent_to_host, v2[1]);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
